// File: rtl/clock_edit_controller.sv
// Mode/edit sequencer for the 24-hour clock: 1 Hz tick, edit enables, increment pulses, blink strobe, idle timeout.
// Optional build macro EDIT_AUTOREPEAT_EN adds auto-repeat of Increment while IncBtn is held.
module clock_edit_controller #(
    parameter int TICK_DIV       = 100000000,
    parameter int REPEAT_DELAY   = 50000000,
    parameter int REPEAT_RATE    = 10000000,
    parameter int TIMEOUT_CYCLES = 1000000000,
    parameter int BLINK_DIV      = 25000000
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       ModeBtn,
    input  logic       IncBtn,
    output logic       SecTick,
    output logic       EditHours,
    output logic       EditMinutes,
    output logic       EditSeconds,
    output logic       Increment,
    output logic       Blink,
    output logic [1:0] Mode
);

    localparam int TW = $clog2(TICK_DIV);
    localparam int IW = $clog2(TIMEOUT_CYCLES);
    localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

    typedef enum logic [1:0] {
        NORMAL   = 2'd0,
        EDIT_HR  = 2'd1,
        EDIT_MIN = 2'd2,
        EDIT_SEC = 2'd3
    } state_t;

    state_t          state, state_nxt;
    logic            mode_prev, inc_prev;
    logic            mode_edge, inc_edge, in_edit, stay_edit, timeout, rep_fire;
    logic [TW-1:0]   presc_cnt, presc_nxt;
    logic [IW-1:0]   idle_cnt, idle_nxt;
    logic [BW-1:0]   blink_cnt, blink_cnt_nxt;
    logic            tick_nxt, inc_nxt, blink_nxt;
    logic            edit_hr_nxt, edit_min_nxt, edit_sec_nxt;

    assign mode_edge = ModeBtn & ~mode_prev;
    assign inc_edge  = IncBtn & ~inc_prev;
    assign in_edit   = (state != NORMAL);
    assign stay_edit = in_edit && (state_nxt == state);
    assign timeout   = in_edit && (idle_cnt == IW'(TIMEOUT_CYCLES - 1));
    assign Mode      = state;

`ifdef EDIT_AUTOREPEAT_EN
    localparam int RW = $clog2(((REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE) + 1);

    logic [RW-1:0] rep_cnt, rep_limit;
    logic          rep_phase, held;

    // Repeat only continues while the press is held in the same edit state.
    assign held      = stay_edit && IncBtn && inc_prev;
    assign rep_limit = rep_phase ? RW'(REPEAT_RATE - 1) : RW'(REPEAT_DELAY - 1);
    assign rep_fire  = held && (rep_cnt == rep_limit);

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            rep_cnt   <= '0;
            rep_phase <= 1'b0;
        end else if (!held) begin
            rep_cnt   <= '0;
            rep_phase <= 1'b0;
        end else if (rep_fire) begin
            rep_cnt   <= '0;
            rep_phase <= 1'b1;
        end else begin
            rep_cnt   <= rep_cnt + 1'b1;
        end
    end
`else
    assign rep_fire = (REPEAT_DELAY < 0) && (REPEAT_RATE < 0);
`endif

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) state <= NORMAL;
        else     state <= state_nxt;
    end

    // A mode edge outranks a timeout in the same cycle.
    always_comb begin
        state_nxt = state;
        if (mode_edge) begin
            case (state)
                NORMAL:   state_nxt = EDIT_HR;
                EDIT_HR:  state_nxt = EDIT_MIN;
                EDIT_MIN: state_nxt = EDIT_SEC;
                default:  state_nxt = NORMAL;
            endcase
        end else if (timeout) begin
            state_nxt = NORMAL;
        end
    end

    always_comb begin
        inc_nxt      = stay_edit && (inc_edge || rep_fire);
        edit_hr_nxt  = (state_nxt == EDIT_HR);
        edit_min_nxt = (state_nxt == EDIT_MIN);
        edit_sec_nxt = (state_nxt == EDIT_SEC);

        // Prescaler counts only while NORMAL is both current and next state.
        presc_nxt = '0;
        tick_nxt  = 1'b0;
        if (state == NORMAL && state_nxt == NORMAL) begin
            if (presc_cnt == TW'(TICK_DIV - 1)) tick_nxt = 1'b1;
            else                                presc_nxt = presc_cnt + 1'b1;
        end

        idle_nxt = '0;
        if (stay_edit && !inc_edge && !Increment) idle_nxt = idle_cnt + 1'b1;

        // Blink phase restarts on any state change and on every Increment.
        blink_nxt     = 1'b1;
        blink_cnt_nxt = '0;
        if (stay_edit && !inc_nxt) begin
            if (blink_cnt == BW'(BLINK_DIV - 1)) begin
                blink_nxt = ~Blink;
            end else begin
                blink_nxt     = Blink;
                blink_cnt_nxt = blink_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            mode_prev   <= 1'b0;
            inc_prev    <= 1'b0;
            presc_cnt   <= '0;
            idle_cnt    <= '0;
            blink_cnt   <= '0;
            SecTick     <= 1'b0;
            EditHours   <= 1'b0;
            EditMinutes <= 1'b0;
            EditSeconds <= 1'b0;
            Increment   <= 1'b0;
            Blink       <= 1'b1;
        end else begin
            mode_prev   <= ModeBtn;
            inc_prev    <= IncBtn;
            presc_cnt   <= presc_nxt;
            idle_cnt    <= idle_nxt;
            blink_cnt   <= blink_cnt_nxt;
            SecTick     <= tick_nxt;
            EditHours   <= edit_hr_nxt;
            EditMinutes <= edit_min_nxt;
            EditSeconds <= edit_sec_nxt;
            Increment   <= inc_nxt;
            Blink       <= blink_nxt;
        end
    end

endmodule

// File: doc/clock_edit_controller.md
Name: clock_edit_controller

Overview:
Mode and edit sequencer for the 24-hour clock. It generates the 1 Hz seconds tick from CLK and walks the user through setting hours, minutes and seconds with two buttons. It drives the per-counter edit-enable and increment controls of the hours/minutes/seconds digit counters, plus a blink strobe for the display. An inactivity timeout returns it to normal run mode.

Parameters:
TICK_DIV, 100000000, CLK cycles per SecTick (>=2)
REPEAT_DELAY, 50000000, cycles IncBtn must be held before auto-repeat starts (>=1)
REPEAT_RATE, 10000000, cycles between auto-repeat pulses (>=1)
TIMEOUT_CYCLES, 1000000000, idle cycles in an edit state before forced return to NORMAL (>=2)
BLINK_DIV, 25000000, cycles per Blink half-period (>=1)

Ports:
CLK  input  1  system clock
RST  input  1  reset, asynchronous, active-high
ModeBtn  input  1  mode button level; already synchronised and debounced
IncBtn  input  1  increment button level; already synchronised and debounced
SecTick  output  1  one-cycle 1 Hz pulse to the seconds counter InTick
EditHours  output  1  edit enable, hours counter
EditMinutes  output  1  edit enable, minutes counter
EditSeconds  output  1  edit enable, seconds counter
Increment  output  1  one-cycle increment pulse, shared by all counters
Blink  output  1  display blank strobe (1 = digits visible)
Mode  output  2  current state encoding

Behaviour:
- All outputs are registered. Counter widths are $clog2(param) as needed. Internal registers ModePrev and IncPrev hold the previous button samples.
- ModeEdge = ModeBtn & ~ModePrev. IncEdge = IncBtn & ~IncPrev. Both are evaluated at a posedge; every effect of an edge is visible immediately after that same edge.
- Reset values: state NORMAL, Mode=0, SecTick=0, EditHours/EditMinutes/EditSeconds=0, Increment=0, Blink=1. All counters and Prev registers reset to 0.
- States and encoding: NORMAL=0, EDIT_HR=1, EDIT_MIN=2, EDIT_SEC=3.
  - ModeEdge advances NORMAL->EDIT_HR->EDIT_MIN->EDIT_SEC->NORMAL.
  - Edit enables are one-hot with the state and all 0 in NORMAL.
- Prescaler:
  - Runs only in NORMAL, counting 0..TICK_DIV-1. SecTick=1 for the single cycle after the count wraps.
  - In any edit state it is held at 0 and SecTick=0. After exiting to NORMAL, the first SecTick occurs TICK_DIV cycles later.
  - On entering EDIT_HR while SecTick is pending that cycle, SecTick is still suppressed.
- Increment:
  - Always 0 in NORMAL; IncBtn is ignored there.
  - In an edit state, IncEdge gives Increment=1 for exactly one cycle.
  - If ModeEdge and IncEdge occur in the same cycle, the mode change wins, Increment stays 0, and the repeat counter clears.
- Timeout:
  - The idle counter clears on entering an edit state, on any ModeEdge/IncEdge, and on any Increment pulse.
  - When it reaches TIMEOUT_CYCLES-1, the state goes to NORMAL (edit enables drop, prescaler restarts). Counter is held at 0 in NORMAL.
- Blink:
  - Forced to 1 in NORMAL.
  - In edit states it toggles every BLINK_DIV cycles and starts at 1 on edit entry.
  - The blink phase restarts (Blink=1) on every state change and on every Increment, so edited digits are visible while changing.
- Asynchronous RST at any time, including mid-edit or mid-repeat, returns everything to reset values. Counter contents are owned by the digit counters and are not touched here.

Optional Feature:
EDIT_AUTOREPEAT_EN
- Defined: while IncBtn stays high in an edit state, the first Increment comes from IncEdge. After REPEAT_DELAY further cycles held, Increment pulses every REPEAT_RATE cycles until release. Release, a ModeEdge or a timeout clears the repeat counter.
- Undefined: exactly one Increment per press and no repeat counter is synthesised.

Test Plan:
(Bench params: TICK_DIV=8, REPEAT_DELAY=20, REPEAT_RATE=5, TIMEOUT_CYCLES=100, BLINK_DIV=4)
- Reset release, both buttons low for 40 cycles -> SecTick pulses at cycles 8,16,24,32,40; Mode=0; all edit enables 0; Blink=1.
- Four single-cycle ModeBtn presses spaced 10 cycles apart -> Mode 1,2,3,0 with matching one-hot enables; no SecTick while Mode!=0; first SecTick 8 cycles after return to 0.
- In EDIT_MIN, three IncBtn presses -> exactly 3 one-cycle Increment pulses with EditMinutes=1; Blink=1 in the cycle after each pulse.
- In EDIT_HR, ModeBtn and IncBtn rise in the same cycle -> Mode=2, Increment stays 0.
- In EDIT_SEC, no button activity -> Mode returns to 0 exactly 100 cycles after the last edge; Blink toggles every 4 cycles meanwhile.
- EDIT_AUTOREPEAT_EN defined, IncBtn held 50 cycles in EDIT_HR -> Increment at hold cycles 0,20,25,30,35,40,45 (7 pulses). Undefined -> 1 pulse.
